// File: rtl/spi_wb_burst_bridge_pkg.sv
// Shared types for the SPI-to-Wishbone bridge: FSM states, response status
// codes and a small elaboration-time helper.
package spi_wb_bridge_pkg;

    typedef enum logic [2:0] {
        HEADER   = 3'd0,
        WDATA    = 3'd1,
        BUS      = 3'd2,
        RESPONSE = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [1:0] ST_TIMEOUT = 2'b00;
    localparam logic [1:0] ST_ACK     = 2'b01;
    localparam logic [1:0] ST_ERR     = 2'b10;
    localparam logic [1:0] ST_RTY     = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_wb_burst_bridge_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus a one-cycle strobe on each
// falling edge of the synchronised SCK.
module spi_wb_pin_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_sck,
    input  logic spi_ss_n,
    input  logic spi_mosi,
    output logic sck_fall,
    output logic ss_n_sync,
    output logic mosi_sync
);

    logic sck_meta, sck_sync, sck_prev;
    logic ss_n_meta;
    logic mosi_meta;

    // Slave select idles high so the bridge starts out deselected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            ss_n_meta <= 1'b1;
            ss_n_sync <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= spi_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ss_n_meta <= spi_ss_n;
            ss_n_sync <= ss_n_meta;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign sck_fall = sck_prev & ~sck_sync;

endmodule

// File: rtl/spi_wb_burst_bridge.sv
// SPI-slave to Wishbone-master bridge with status frame and bus timeout.
// Define SPI_WB_BURST_EN for auto-incrementing bursts within one ss_n frame.
module spi_wb_burst_bridge
    import spi_wb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sck,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic              rty_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [2:0]        dbg_state
);

    localparam int HDR_LEN = 1 + ADDR_W;
    localparam int RESP_W  = DATA_W + 3;
    localparam int CNT_W   = $clog2(max_int(1 + ADDR_W, DATA_W + 3)) + 1;
    localparam int TO_W    = $clog2(TIMEOUT + 2);

    logic              sck_fall, ss_n_s, mosi_s;
    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [RESP_W-1:0] resp_sr;
    logic [CNT_W-1:0]  resp_last;
    logic              term;
    logic [1:0]        term_st;

    spi_wb_pin_sync u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .spi_sck   (spi_sck),
        .spi_ss_n  (spi_ss_n),
        .spi_mosi  (spi_mosi),
        .sck_fall  (sck_fall),
        .ss_n_sync (ss_n_s),
        .mosi_sync (mosi_s)
    );

    // Wishbone classic handshake: cyc_o/stb_o stay high with adr/we/dat frozen
    // until ack_i, err_i or rty_i is sampled (ack > err > rty) or the timeout hits.
    always_comb begin
        term    = 1'b1;
        term_st = ST_TIMEOUT;
        if (ack_i)
            term_st = ST_ACK;
        else if (err_i)
            term_st = ST_ERR;
        else if (rty_i)
            term_st = ST_RTY;
        else if (!((TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1))))
            term = 1'b0;
    end

    // Writes answer with start+status only; reads append the data word.
    assign resp_last = we_o ? CNT_W'(2) : CNT_W'(RESP_W - 1);
    assign stb_o     = cyc_o;
    assign dbg_state = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= HEADER;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            resp_sr  <= '0;
            spi_miso <= 1'b0;
            cyc_o    <= 1'b0;
            we_o     <= 1'b0;
            adr_o    <= '0;
            dat_o    <= '0;
        end else if (ss_n_s) begin
            // Deselect aborts everything, including an outstanding bus cycle.
            state    <= HEADER;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            spi_miso <= 1'b0;
            cyc_o    <= 1'b0;
        end else begin
            case (state)
                HEADER: if (sck_fall) begin
                    spi_miso      <= 1'b0;
                    {we_o, adr_o} <= {adr_o, mosi_s};
                    if (bit_cnt == CNT_W'(HDR_LEN - 1)) begin
                        bit_cnt <= '0;
                        if (adr_o[ADDR_W-1]) begin
                            state <= WDATA;
                        end else begin
                            state  <= BUS;
                            cyc_o  <= 1'b1;
                            to_cnt <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                WDATA: if (sck_fall) begin
                    spi_miso <= 1'b0;
                    dat_o    <= {dat_o[DATA_W-2:0], mosi_s};
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt <= '0;
                        state   <= BUS;
                        cyc_o   <= 1'b1;
                        to_cnt  <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                BUS: begin
                    if (sck_fall)
                        spi_miso <= 1'b0;
                    if (term) begin
                        cyc_o   <= 1'b0;
                        state   <= RESPONSE;
                        bit_cnt <= '0;
                        resp_sr <= {1'b1, term_st, (we_o ? {DATA_W{1'b0}} : dat_i)};
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                RESPONSE: if (sck_fall) begin
                    spi_miso <= resp_sr[RESP_W-1];
                    resp_sr  <= {resp_sr[RESP_W-2:0], 1'b0};
                    if (bit_cnt == resp_last) begin
                        bit_cnt <= '0;
`ifdef SPI_WB_BURST_EN
                        adr_o <= adr_o + ADDR_W'(1);
                        if (we_o) begin
                            state <= WDATA;
                        end else begin
                            state  <= BUS;
                            cyc_o  <= 1'b1;
                            to_cnt <= '0;
                        end
`else
                        state <= DONE;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DONE: if (sck_fall) begin
                    spi_miso <= 1'b0;
                end
                default: state <= HEADER;
            endcase
        end
    end

endmodule
